piso_serializer: RTL and testbench

Parametrised parallel-in/serial-out shifter, next generation of the 4-bit load/shift register. Accepts a WIDTH-bit word through a valid/ready handshake, then emits it one bit per enabled cycle, MSB-first or LSB-first. Flags the last bit of each frame and supports gap-free back-to-back frames. Sits between a word-wide producer and a bit-serial link or line driver.

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_serializer_if.sv | 25 ++
 rtl/piso_bit_counter.sv | 27 ++
 rtl/piso_serializer.sv | 73 +++++++
 tb/tb_piso_serializer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer slice.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Counter must hold WIDTH itself, not just WIDTH-1.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake plus serial bit stream between producer, serializer and consumer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             shift_en;
  logic             serial_out;
  logic             serial_valid;
  logic             serial_last;
  logic             busy;

  modport master (
    output load_valid, parallel_in, shift_en,
    input  load_ready, serial_out, serial_valid, serial_last, busy
  );

  modport slave (
    input  load_valid, parallel_in, shift_en,
    output load_ready, serial_out, serial_valid, serial_last, busy
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking the bits left in the current frame.
module piso_bit_counter #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [CntW-1:0] i_load_val,
  input  logic            i_dec,
  output logic            o_is_one
);

  logic [CntW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CntW'(1);
    end
  end

  assign o_is_one = (r_count == CntW'(1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load and gap-free back-to-back frames.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  piso_serializer_if.slave   bus
);

  localparam int unsigned CntW = cnt_w(WIDTH);

  state_e           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shifted;
  logic             w_head;
  logic             w_is_one;
  logic             w_consume;
  logic             w_ready;
  logic             w_accept;
  logic             w_active;

  assign w_active  = (r_state == ST_SHIFT);
  assign w_consume = w_active && bus.shift_en;
  // Ready on the last consumed bit lets the next word load with no idle cycle.
  assign w_ready   = (r_state == ST_IDLE) || (w_is_one && w_consume);
  assign w_accept  = bus.load_valid && w_ready;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_head    = r_shift[WIDTH-1];
      assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign w_head    = r_shift[0];
      assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_shift <= bus.parallel_in;
    end else if (w_consume) begin
      r_shift <= w_shifted;
      if (w_is_one) begin
        r_state <= ST_IDLE;
      end
    end
  end

  piso_bit_counter #(
    .CntW (CntW)
  ) u_bit_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (CntW'(WIDTH)),
    .i_dec      (w_consume),
    .o_is_one   (w_is_one)
  );

  assign bus.load_ready   = w_ready;
  assign bus.serial_valid = w_active;
  assign bus.serial_out   = w_active && w_head;
  assign bus.serial_last  = w_active && w_is_one;
  assign bus.busy         = w_active;

endmodule

// File: tb/tb_piso_serializer.sv
// Drives MSB-first and LSB-first serializers in lockstep against a bit-queue reference model.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Remaining frame bits in transmit order, one queue per bit order.
  bit qm[$];
  bit ql[$];

  piso_serializer_if #(.WIDTH(W)) bus_m ();
  piso_serializer_if #(.WIDTH(W)) bus_l ();

  piso_serializer #(
    .WIDTH     (W),
    .MSB_FIRST (1'b1)
  ) u_dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  piso_serializer #(
    .WIDTH     (W),
    .MSB_FIRST (1'b0)
  ) u_dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit lv, input logic [W-1:0] w, input bit se);
    bus_m.load_valid  = lv;
    bus_m.parallel_in = w;
    bus_m.shift_en    = se;
    bus_l.load_valid  = lv;
    bus_l.parallel_in = w;
    bus_l.shift_en    = se;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " msb out"},   32'(bus_m.serial_out),   32'(0));
    check({tag, " msb valid"}, 32'(bus_m.serial_valid), 32'(0));
    check({tag, " msb last"},  32'(bus_m.serial_last),  32'(0));
    check({tag, " msb busy"},  32'(bus_m.busy),         32'(0));
    check({tag, " msb ready"}, 32'(bus_m.load_ready),   32'(1));
    check({tag, " lsb out"},   32'(bus_l.serial_out),   32'(0));
    check({tag, " lsb valid"}, 32'(bus_l.serial_valid), 32'(0));
    check({tag, " lsb ready"}, 32'(bus_l.load_ready),   32'(1));
  endtask

  task automatic check_outs(input string tag, input bit se);
    bit v;
    bit rdy;
    v   = (qm.size() > 0);
    rdy = (qm.size() == 0) || ((qm.size() == 1) && se);
    check({tag, " msb valid"}, 32'(bus_m.serial_valid), 32'(v));
    check({tag, " msb out"},   32'(bus_m.serial_out),   32'(v ? qm[0] : 1'b0));
    check({tag, " msb last"},  32'(bus_m.serial_last),  32'(qm.size() == 1));
    check({tag, " msb busy"},  32'(bus_m.busy),         32'(v));
    check({tag, " msb ready"}, 32'(bus_m.load_ready),   32'(rdy));
    check({tag, " lsb valid"}, 32'(bus_l.serial_valid), 32'(v));
    check({tag, " lsb out"},   32'(bus_l.serial_out),   32'(v ? ql[0] : 1'b0));
    check({tag, " lsb last"},  32'(bus_l.serial_last),  32'(ql.size() == 1));
    check({tag, " lsb ready"}, 32'(bus_l.load_ready),   32'(rdy));
  endtask

  // One clock: called at a falling edge, returns at the next falling edge.
  task automatic step(input string tag, input bit lv, input logic [W-1:0] w, input bit se,
                      output bit acc);
    bit rdy;
    drive(lv, w, se);
    #1;
    check_outs(tag, se);
    rdy = (qm.size() == 0) || ((qm.size() == 1) && se);
    acc = lv && rdy;
    @(posedge clk);
    if ((qm.size() > 0) && se) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (acc) begin
      for (int i = W - 1; i >= 0; i--) qm.push_back(w[i]);
      for (int i = 0; i < int'(W); i++) ql.push_back(w[i]);
    end
    @(negedge clk);
  endtask

  initial begin
    bit             acc;
    bit             have;
    logic [W-1:0]   word;
    logic [W-1:0]   pend[$];

    rst_n = 1'b0;
    drive(1'b1, 8'hA5, 1'b1);
    #2;
    check_reset("por");
    @(negedge clk);
    check_reset("por held");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) step("idle", 1'b0, 8'h00, i[0], acc);

    step("a5", 1'b1, 8'hA5, 1'b1, acc);
    for (int i = 0; i < 9; i++) step("a5", 1'b0, 8'h00, 1'b1, acc);

    step("x01", 1'b1, 8'h01, 1'b1, acc);
    for (int i = 0; i < 9; i++) step("x01", 1'b0, 8'h00, 1'b1, acc);

    pend.push_back(8'hFF);
    pend.push_back(8'h00);
    for (int c = 0; c < 20; c++) begin
      step("b2b", pend.size() > 0, (pend.size() > 0) ? pend[0] : 8'h00, 1'b1, acc);
      if (acc) void'(pend.pop_front());
    end
    check("b2b drained", 32'(pend.size()), 32'(0));

    step("stall", 1'b1, 8'h81, 1'b1, acc);
    have = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step("stall", have && (c >= 4), 8'h5A, !((c >= 3) && (c <= 5)), acc);
      if (acc) begin
        have = 1'b0;
        check("stall accept cycle", 32'(c), 32'(11));
      end
    end
    check("stall accepted", 32'(have), 32'(0));

    step("mid", 1'b1, 8'hC3, 1'b1, acc);
    for (int i = 0; i < 4; i++) step("mid", 1'b0, 8'h00, 1'b1, acc);
    #2;
    rst_n = 1'b0;
    drive(1'b1, 8'h77, 1'b1);
    #1;
    check_reset("mid rst");
    qm.delete();
    ql.delete();
    @(negedge clk);
    check_reset("mid rst held");
    @(negedge clk);
    rst_n = 1'b1;
    step("x3c", 1'b1, 8'h3C, 1'b1, acc);
    for (int i = 0; i < 9; i++) step("x3c", 1'b0, 8'h00, 1'b1, acc);

    have = 1'b0;
    word = '0;
    for (int c = 0; c < 400; c++) begin
      if (!have && ($urandom_range(0, 2) != 0)) begin
        have = 1'b1;
        word = W'($urandom);
      end
      step("rand", have, word, $urandom_range(0, 3) != 0, acc);
      if (acc) have = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
